// File: rtl/i2c_master_lite.sv
// Single-transaction I2C master: one address/RW frame, one data word, STOP.
// Bus outputs are registered, so the waveform trails the slot counters by one clock.
module i2c_master_lite #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [DATA_W-1:0] rdata,
  output logic              scl,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_RW    = 3'd3;
  localparam logic [2:0] S_ACK1  = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_ACK2  = 3'd6;
  localparam logic [2:0] S_STOP  = 3'd7;

  localparam int CW = $clog2(CLK_DIV);
  localparam int MW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BW = $clog2(MW + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] A_LAST = BW'(ADDR_W - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_W - 1);

  logic [2:0]        state;
  logic [CW-1:0]     ccnt;
  logic [1:0]        qcnt;
  logic [BW-1:0]     bcnt;
  logic              rw_q;
  logic              samp;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic              q_end;
  logic              slot_end;
  logic              scl_c;
  logic              oe_c;

  assign sda_out  = 1'b0;
  assign q_end    = (ccnt == C_LAST);
  assign slot_end = q_end && (qcnt == 2'd3);

  // A 1 on the bus is always a release; only zeros are driven.
  always_comb begin
    scl_c = 1'b1;
    oe_c  = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_START: oe_c = qcnt[1];
      S_ADDR: begin
        scl_c = qcnt[1];
        oe_c  = ~addr_sh[ADDR_W-1];
      end
      S_RW: begin
        scl_c = qcnt[1];
        oe_c  = ~rw_q;
      end
      S_ACK1, S_ACK2: scl_c = qcnt[1];
      S_DATA: begin
        scl_c = qcnt[1];
        oe_c  = ~rw_q & ~data_sh[DATA_W-1];
      end
      S_STOP: begin
        scl_c = qcnt[1];
        oe_c  = (qcnt != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ccnt    <= '0;
      qcnt    <= '0;
      bcnt    <= '0;
      rw_q    <= 1'b0;
      samp    <= 1'b0;
      addr_sh <= '0;
      data_sh <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      scl    <= scl_c;
      sda_oe <= oe_c;
      if (state == S_IDLE) begin
        done <= 1'b0;
        ccnt <= '0;
        qcnt <= '0;
        bcnt <= '0;
        if (start) begin
          state   <= S_START;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          rw_q    <= rw;
          addr_sh <= addr;
          data_sh <= wdata;
        end
      end else begin
        ccnt <= q_end ? '0 : ccnt + 1'b1;
        if (q_end) qcnt <= qcnt + 1'b1;
        if (q_end && qcnt == 2'd2) samp <= sda_in;
        if (slot_end) begin
          unique case (state)
            S_START: state <= S_ADDR;
            S_ADDR: begin
              addr_sh <= addr_sh << 1;
              bcnt    <= bcnt + 1'b1;
              if (bcnt == A_LAST) begin
                bcnt  <= '0;
                state <= S_RW;
              end
            end
            S_RW: state <= S_ACK1;
            S_ACK1: begin
              if (samp) begin
                ack_err <= 1'b1;
                state   <= S_STOP;
              end else begin
                state <= S_DATA;
              end
            end
            // Reads shift bus samples in behind the outgoing write bits.
            S_DATA: begin
              data_sh <= {data_sh[DATA_W-2:0], samp};
              bcnt    <= bcnt + 1'b1;
              if (bcnt == D_LAST) begin
                bcnt  <= '0;
                state <= S_ACK2;
              end
            end
            S_ACK2: begin
              if (!rw_q && samp) ack_err <= 1'b1;
              state <= S_STOP;
            end
            S_STOP: begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (rw_q && !ack_err) rdata <= data_sh;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule
